// File: rtl/rb_useq.sv
// rtl/rb_useq.sv - microinstruction sequencer for the 36-entry register bank
//
// Runs one decoded microinstruction at a time through RD -> EX -> MEM -> WB
// and drives the bank's address buses and one-cycle read/write strobes.
// Memory transfers go through the working register with a mem_req/mem_ack
// handshake bounded by MEM_TIMEOUT cycles.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      run the microinstruction on ui_* (IDLE only)
//   ui_busA/B/C, ui_MC, ui_wen decoded microinstruction fields
//   mem_ack                    memory transfer complete (sampled in MEM only)
//   busy, done, err            status: in flight, completion pulse, sticky error
//   busA, busB, busC           bank address buses (hold between instructions)
//   regRead, workRegRead       bank read strobes
//   regWrite, workRegWrite     bank write strobes
//   MC, mem_req                memory control and transfer request
//   csel                       bank write-data select (0 ALU, 1 Mdata)
module rb_useq #(
  parameter int MEM_TIMEOUT = 15,
  parameter int WR_IDX      = 34,
  parameter int AUX_IDX     = 35
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] ui_busA,
  input  logic [5:0] ui_busB,
  input  logic [5:0] ui_busC,
  input  logic [1:0] ui_MC,
  input  logic       ui_wen,
  input  logic       mem_ack,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [4:0] busA,
  output logic [5:0] busB,
  output logic [5:0] busC,
  output logic       regRead,
  output logic       workRegRead,
  output logic       regWrite,
  output logic       workRegWrite,
  output logic [1:0] MC,
  output logic       mem_req,
  output logic       csel
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_EX,
    S_MEM,
    S_WB,
    S_DONE
  } state_t;

  localparam logic [5:0] WR_A     = 6'(WR_IDX);
  localparam logic [5:0] AUX_A    = 6'(AUX_IDX);
  localparam logic [5:0] LAST_IDX = 6'd35;
  localparam logic [3:0] TMO_LAST = 4'(MEM_TIMEOUT - 1);

  state_t     state;
  logic [5:0] l_busc;
  logic [1:0] l_mc;
  logic       l_wen;
  logic [3:0] tcnt;
  logic       bad;

  // Illegal microinstruction: caught at accept so no strobe is ever issued.
  always_comb begin
    bad = 1'b0;
    if (ui_busB > LAST_IDX)                bad = 1'b1;
    if (ui_wen && (ui_busC > LAST_IDX))    bad = 1'b1;
    if (ui_MC == 2'b11)                    bad = 1'b1;
    if (ui_wen && (ui_busC == AUX_A))      bad = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      l_busc       <= '0;
      l_mc         <= '0;
      l_wen        <= 1'b0;
      tcnt         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      busA         <= '0;
      busB         <= '0;
      busC         <= '0;
      regRead      <= 1'b0;
      workRegRead  <= 1'b0;
      regWrite     <= 1'b0;
      workRegWrite <= 1'b0;
      MC           <= '0;
      mem_req      <= 1'b0;
      csel         <= 1'b0;
    end else begin
      // Every strobe and done is a single-cycle pulse; they default low.
      regRead      <= 1'b0;
      workRegRead  <= 1'b0;
      regWrite     <= 1'b0;
      workRegWrite <= 1'b0;
      done         <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            l_busc <= ui_busC;
            l_mc   <= ui_MC;
            l_wen  <= ui_wen;
            busy   <= 1'b1;
            err    <= bad;
            if (bad) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state       <= S_RD;
              busA        <= ui_busA;
              busB        <= ui_busB;
              regRead     <= 1'b1;
              // WR must be read when it is an operand or the source of MW.
              workRegRead <= ({1'b0, ui_busA} == WR_A) || (ui_busB == WR_A) || ui_MC[0];
            end
          end
        end

        S_RD: begin
          state <= S_EX;
        end

        S_EX: begin
          if (l_mc != 2'b00) begin
            state <= S_MEM;
            MC    <= l_mc;
            tcnt  <= '0;
          end else if (l_wen) begin
            state        <= S_WB;
            busC         <= l_busc;
            csel         <= 1'b0;
            regWrite     <= 1'b1;
            workRegWrite <= (l_busc == WR_A);
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end

        S_MEM: begin
          // First MEM cycle presents MC; mem_req rises one cycle later.
          if (!mem_req) begin
            mem_req <= 1'b1;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            if (l_mc[1]) begin
              // MR lands in WR from Mdata regardless of ui_wen.
              state        <= S_WB;
              busC         <= WR_A;
              csel         <= 1'b1;
              regWrite     <= 1'b1;
              workRegWrite <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end else if (tcnt == TMO_LAST) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            state   <= S_DONE;
            done    <= 1'b1;
          end else begin
            tcnt <= tcnt + 4'd1;
          end
        end

        S_WB: begin
          state <= S_DONE;
          done  <= 1'b1;
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rb_useq.sv
// tb/tb_rb_useq.sv - self-checking bench for rb_useq
module tb_rb_useq;

  localparam int TMO = 15;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] ui_busA;
  logic [5:0] ui_busB;
  logic [5:0] ui_busC;
  logic [1:0] ui_MC;
  logic       ui_wen;
  logic       mem_ack;
  logic       busy, done, err;
  logic [4:0] busA;
  logic [5:0] busB, busC;
  logic       regRead, workRegRead, regWrite, workRegWrite;
  logic [1:0] MC;
  logic       mem_req, csel;

  int n_checks = 0;
  int n_fail   = 0;

  rb_useq #(.MEM_TIMEOUT(TMO), .WR_IDX(34), .AUX_IDX(35)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ui_busA(ui_busA), .ui_busB(ui_busB), .ui_busC(ui_busC),
    .ui_MC(ui_MC), .ui_wen(ui_wen), .mem_ack(mem_ack),
    .busy(busy), .done(done), .err(err),
    .busA(busA), .busB(busB), .busC(busC),
    .regRead(regRead), .workRegRead(workRegRead),
    .regWrite(regWrite), .workRegWrite(workRegWrite),
    .MC(MC), .mem_req(mem_req), .csel(csel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int rr;
    int wrr;
    int rw;
    int rw_cyc;
    int busc;
    int csel;
    int wrw;
    int mreq;
    int done_cyc;
    int err;
  } exp_t;

  // Observations of one instruction; cycle 1 is the cycle after the start edge.
  int rr_cnt, rr_cyc, o_busa, o_busb, wrr_cnt;
  int rw_cnt, rw_cyc, o_busc, o_csel, wrw_cnt;
  int mreq_cnt, done_cnt, done_cyc, o_err, o_err1, o_busy1;

  // Expected behaviour derived from the instruction fields and ack delay k
  // (k = 0 means memory never answers).
  function automatic exp_t model(int a, int b, int c, int mc, int wen, int k);
    exp_t e;
    e = '{default: 0};
    if (b > 35 || (wen != 0 && c > 35) || mc == 3 || (wen != 0 && c == 35)) begin
      e.err = 1;
      e.done_cyc = 1;
      return e;
    end
    e.rr  = 1;
    e.wrr = (a == 34 || b == 34 || mc == 1) ? 1 : 0;
    if (mc == 0) begin
      if (wen != 0) begin
        e.rw = 1; e.rw_cyc = 3; e.busc = c; e.csel = 0;
        e.wrw = (c == 34) ? 1 : 0; e.done_cyc = 4;
      end else begin
        e.done_cyc = 3;
      end
    end else if (k >= 1 && k <= TMO) begin
      e.mreq = k;
      if (mc == 2) begin
        e.rw = 1; e.rw_cyc = 4 + k; e.busc = 34; e.csel = 1; e.wrw = 1;
        e.done_cyc = 5 + k;
      end else begin
        e.done_cyc = 4 + k;
      end
    end else begin
      e.mreq = TMO; e.err = 1; e.done_cyc = 4 + TMO;
    end
    return e;
  endfunction

  // Issue one instruction and record what the DUT does until it is idle again.
  task automatic run_instr(input int a, input int b, input int c, input int mc,
                           input int wen, input int k, input bit early_ack);
    bit fin;
    rr_cnt = 0; rr_cyc = -1; o_busa = -1; o_busb = -1; wrr_cnt = 0;
    rw_cnt = 0; rw_cyc = -1; o_busc = -1; o_csel = -1; wrw_cnt = 0;
    mreq_cnt = 0; done_cnt = 0; done_cyc = -1; o_err = -1; o_err1 = -1; o_busy1 = -1;
    ui_busA = 5'(a); ui_busB = 6'(b); ui_busC = 6'(c);
    ui_MC = 2'(mc); ui_wen = 1'(wen); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    fin = 1'b0;
    for (int cyc = 1; cyc <= 40 && !fin; cyc++) begin
      if (cyc == 1) begin o_err1 = int'(err); o_busy1 = int'(busy); end
      if (regRead) begin rr_cnt++; rr_cyc = cyc; o_busa = int'(busA); o_busb = int'(busB); end
      if (workRegRead) wrr_cnt++;
      if (regWrite) begin rw_cnt++; rw_cyc = cyc; o_busc = int'(busC); o_csel = int'(csel); end
      if (workRegWrite) wrw_cnt++;
      if (mem_req) begin
        mreq_cnt++;
        mem_ack = (k > 0 && mreq_cnt == k);
      end else begin
        mem_ack = early_ack && (cyc <= 2);
      end
      if (done) begin done_cnt++; done_cyc = cyc; o_err = int'(err); fin = 1'b1; end
      @(negedge clk);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mem_ack = 1'b0;
    ui_busA = '0; ui_busB = '0; ui_busC = '0; ui_MC = '0; ui_wen = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, err, regRead, workRegRead, regWrite, workRegWrite, mem_req, csel} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0", {busy, done, err, regRead, workRegRead, regWrite, workRegWrite, mem_req, csel});
    end
    n_checks++;
    if ({busA, busB, busC, MC} !== 19'b0) begin
      n_fail++;
      $display("FAIL reset_bus: got %h want 0", {busA, busB, busC, MC});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reg_write();
    run_instr(1, 2, 3, 0, 1, 0, 1'b0);
    n_checks++;
    if (rr_cyc != 1 || rr_cnt != 1) begin n_fail++; $display("FAIL regw_rd: cyc %0d cnt %0d want 1 1", rr_cyc, rr_cnt); end
    n_checks++;
    if (o_busy1 != 1) begin n_fail++; $display("FAIL regw_busy: got %0d want 1", o_busy1); end
    n_checks++;
    if (rw_cyc != 3 || rw_cnt != 1 || o_busc != 3 || o_csel != 0) begin
      n_fail++; $display("FAIL regw_wb: cyc %0d cnt %0d busC %0d csel %0d want 3 1 3 0", rw_cyc, rw_cnt, o_busc, o_csel);
    end
    n_checks++;
    if (done_cyc != 4 || o_err != 0) begin n_fail++; $display("FAIL regw_done: cyc %0d err %0d want 4 0", done_cyc, o_err); end
  endtask

  task automatic test_mem_read();
    run_instr(5, 7, 9, 2, 0, 3, 1'b0);
    n_checks++;
    if (mreq_cnt != 3) begin n_fail++; $display("FAIL mr_req: got %0d want 3", mreq_cnt); end
    n_checks++;
    if (rw_cyc != 7 || o_busc != 34 || o_csel != 1 || wrw_cnt != 1) begin
      n_fail++; $display("FAIL mr_wb: cyc %0d busC %0d csel %0d wrw %0d want 7 34 1 1", rw_cyc, o_busc, o_csel, wrw_cnt);
    end
    n_checks++;
    if (done_cyc != 8 || o_err != 0) begin n_fail++; $display("FAIL mr_done: cyc %0d err %0d want 8 0", done_cyc, o_err); end
  endtask

  task automatic test_mem_timeout();
    run_instr(0, 1, 2, 1, 0, 0, 1'b0);
    n_checks++;
    if (mreq_cnt != TMO) begin n_fail++; $display("FAIL tmo_req: got %0d want %0d", mreq_cnt, TMO); end
    n_checks++;
    if (rw_cnt != 0 || wrr_cnt != 1) begin n_fail++; $display("FAIL tmo_strobes: rw %0d wrr %0d want 0 1", rw_cnt, wrr_cnt); end
    n_checks++;
    if (done_cyc != 4 + TMO || o_err != 1) begin n_fail++; $display("FAIL tmo_done: cyc %0d err %0d want %0d 1", done_cyc, o_err, 4 + TMO); end
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", err); end
    run_instr(1, 2, 3, 0, 1, 0, 1'b0);
    n_checks++;
    if (o_err1 != 0 || done_cyc != 4) begin n_fail++; $display("FAIL tmo_clear: err %0d done %0d want 0 4", o_err1, done_cyc); end
  endtask

  task automatic test_validation();
    int flds[3][5] = '{'{1, 2, 35, 0, 1}, '{1, 2, 3, 3, 0}, '{1, 40, 3, 0, 0}};
    for (int i = 0; i < 3; i++) begin
      run_instr(flds[i][0], flds[i][1], flds[i][2], flds[i][3], flds[i][4], 1, 1'b0);
      n_checks++;
      if (done_cyc != 1 || o_err != 1 || rr_cnt != 0 || wrr_cnt != 0 || rw_cnt != 0 || wrw_cnt != 0 || mreq_cnt != 0) begin
        n_fail++;
        $display("FAIL valid_%0d: done %0d err %0d rr %0d rw %0d mreq %0d want 1 1 0 0 0", i, done_cyc, o_err, rr_cnt, rw_cnt, mreq_cnt);
      end
    end
  endtask

  task automatic test_ack_outside_mem();
    run_instr(3, 4, 5, 2, 1, 2, 1'b1);
    n_checks++;
    if (mreq_cnt != 2 || done_cyc != 7 || o_busc != 34) begin
      n_fail++; $display("FAIL early_ack_mr: mreq %0d done %0d busC %0d want 2 7 34", mreq_cnt, done_cyc, o_busc);
    end
    run_instr(3, 4, 6, 0, 1, 0, 1'b1);
    n_checks++;
    if (done_cyc != 4 || o_busc != 6) begin n_fail++; $display("FAIL early_ack_reg: done %0d busC %0d want 4 6", done_cyc, o_busc); end
  endtask

  task automatic test_reset_mid_mem();
    int waited;
    int stray;
    ui_busA = 5'd1; ui_busB = 6'd2; ui_busC = 6'd3; ui_MC = 2'b10; ui_wen = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (!mem_req && waited < 10) begin @(negedge clk); waited++; end
    n_checks++;
    if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mem_enter: mem_req %b want 1", mem_req); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || regWrite !== 1'b0) begin
      n_fail++; $display("FAIL rst_mem_async: mem_req %b busy %b regWrite %b want 0 0 0", mem_req, busy, regWrite);
    end
    stray = 0;
    repeat (3) begin @(negedge clk); if (regWrite || done) stray++; end
    rst_n = 1'b1;
    repeat (2) begin @(negedge clk); if (regWrite || done) stray++; end
    n_checks++;
    if (stray != 0) begin n_fail++; $display("FAIL rst_mem_partial: got %0d strobes want 0", stray); end
    run_instr(1, 2, 3, 0, 1, 0, 1'b0);
    n_checks++;
    if (rr_cyc != 1 || rw_cyc != 3 || done_cyc != 4) begin
      n_fail++; $display("FAIL rst_mem_after: rd %0d wb %0d done %0d want 1 3 4", rr_cyc, rw_cyc, done_cyc);
    end
  endtask

  task automatic test_back_to_back();
    int rd_q[$];
    int dn_q[$];
    ui_busA = 5'd4; ui_busB = 6'd5; ui_busC = 6'd6; ui_MC = 2'b00; ui_wen = 1'b1;
    start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (regRead) rd_q.push_back(cyc);
      if (done) dn_q.push_back(cyc);
    end
    start = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (rd_q.size() != 4 || dn_q.size() != 4) begin
      n_fail++; $display("FAIL b2b_count: rd %0d done %0d want 4 4", rd_q.size(), dn_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (rd_q[i] != 1 + 5 * i || dn_q[i] != 4 + 5 * i) begin
          n_fail++; $display("FAIL b2b_slot%0d: rd %0d done %0d want %0d %0d", i, rd_q[i], dn_q[i], 1 + 5 * i, 4 + 5 * i);
        end
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    int a, b, c, mc, wen, k;
    for (int n = 0; n < 40; n++) begin
      a   = $urandom_range(0, 31);
      b   = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 35) : $urandom_range(36, 63);
      c   = ($urandom_range(0, 3) == 0) ? $urandom_range(34, 37) : $urandom_range(0, 35);
      mc  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      wen = $urandom_range(0, 1);
      k   = $urandom_range(0, 17);
      e = model(a, b, c, mc, wen, k);
      run_instr(a, b, c, mc, wen, k, 1'b0);
      n_checks++;
      if (done_cyc != e.done_cyc || done_cnt != 1 || o_err != e.err) begin
        n_fail++; $display("FAIL rnd%0d_done: cyc %0d err %0d want %0d %0d", n, done_cyc, o_err, e.done_cyc, e.err);
      end
      n_checks++;
      if (rr_cnt != e.rr || wrr_cnt != e.wrr || (e.rr == 1 && (rr_cyc != 1 || o_busa != a || o_busb != b))) begin
        n_fail++; $display("FAIL rnd%0d_rd: rr %0d wrr %0d busA %0d busB %0d want %0d %0d %0d %0d", n, rr_cnt, wrr_cnt, o_busa, o_busb, e.rr, e.wrr, a, b);
      end
      n_checks++;
      if (rw_cnt != e.rw || wrw_cnt != e.wrw || (e.rw == 1 && (rw_cyc != e.rw_cyc || o_busc != e.busc || o_csel != e.csel))) begin
        n_fail++; $display("FAIL rnd%0d_wb: rw %0d wrw %0d cyc %0d busC %0d csel %0d want %0d %0d %0d %0d %0d", n, rw_cnt, wrw_cnt, rw_cyc, o_busc, o_csel, e.rw, e.wrw, e.rw_cyc, e.busc, e.csel);
      end
      n_checks++;
      if (mreq_cnt != e.mreq) begin n_fail++; $display("FAIL rnd%0d_mreq: got %0d want %0d", n, mreq_cnt, e.mreq); end
    end
  endtask

  initial begin
    test_reset();
    test_reg_write();
    test_mem_read();
    test_mem_timeout();
    test_validation();
    test_ack_outside_mem();
    test_reset_mid_mem();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rb_useq.md
# rb_useq

Microinstruction sequencer for the 36-entry, 16-bit register bank (entries 0..35, working register WR = 34, AUX = 35, output ports PO0/PO1 = 30/31). It accepts one decoded microinstruction at a time, drives the bank's address buses and single-cycle read/write strobes in a fixed RD→EX→MEM→WB order, and runs the MR/MW handshake with memory through WR. It sits between the microcode ROM/decoder and the register bank, and it is the only agent allowed to drive the bank's control inputs.

## Interface
Parameters:
- MEM_TIMEOUT, 15, maximum cycles to wait for mem_ack before aborting (4-bit counter)
- WR_IDX, 34, working-register index
- AUX_IDX, 35, write-protected auxiliary index

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request to run the microinstruction on ui_* (valid in IDLE only)
- ui_busA  in  5  A-operand register index
- ui_busB  in  6  B-operand register index
- ui_busC  in  6  destination register index
- ui_MC  in  2  bit0 MW (memory write from WR), bit1 MR (memory read into WR)
- ui_wen  in  1  write the ALU result to ui_busC
- mem_ack  in  1  memory completed the current transfer
- busy  out  1  instruction in flight (high in every state except IDLE)
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error flag, cleared by the next accepted start
- busA  out  5 / busB  out  6 / busC  out  6  register bank address buses
- regRead, workRegRead, regWrite, workRegWrite  out  1 each  bank strobes
- MC  out  2  memory control presented to the bank
- mem_req  out  1  memory transfer request
- csel  out  1  bank write-data select: 0 ALU result, 1 Mdata

## Operation
- States: IDLE, RD, EX, MEM, WB, DONE. One-hot or binary encoding, implementer's choice.
- IDLE: when start=1, latch all ui_* fields, clear err, and go to RD. start is ignored in every other state.
- Validation at accept:
  - busB > 35, or busC > 35 with ui_wen=1, sets err.
  - ui_MC = 2'b11 sets err.
  - ui_wen=1 with busC = AUX_IDX sets err.
  - Any of these errors sends the FSM straight to DONE. No strobe is issued.
- RD: drive busA/busB. Pulse regRead for 1 cycle. Pulse workRegRead as well if busA or busB = WR_IDX, or if MW is set.
- EX: single cycle for the ALU. Go to MEM if MC≠0; otherwise go to WB if a write is pending; otherwise go to DONE.
- MEM: drive MC and hold mem_req high until mem_ack. On mem_ack, go to WB for MR, or to DONE for MW. If MEM_TIMEOUT cycles pass without ack, set err, drop mem_req, and go to DONE without writing.
- WB:
  - MR forces busC = WR_IDX and csel=1, and overrides ui_wen.
  - Otherwise busC = latched ui_busC and csel=0.
  - Pulse regWrite for 1 cycle. Pulse workRegWrite too when busC = WR_IDX.
- DONE: pulse done for 1 cycle, then return to IDLE.
- Every strobe is a clean 0→1→0 pulse of exactly one cycle, because the bank reacts to strobe edges.

## Timing
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - All strobes, mem_req, done, busy, err, and csel are 0.
  - MC is 0, and busA/busB/busC are 0.
  - Timeout counter is 0.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Latency, counting the start-sample edge as cycle 0:
  - Register-only instruction with write: RD at 1, EX at 2, WB at 3, done at 4. The next start is accepted at cycle 5.
  - No write and no memory: done at 3.
  - Memory access with ack arriving k cycles after mem_req rises (k ≥ 1): MR gives done at 4+k+1, MW gives done at 4+k.
  - Validation error: done at 1.
- mem_ack is sampled only in MEM. An ack in the same cycle mem_req first rises counts (k=1). An ack outside MEM is ignored.
- Timeout: with no ack, mem_req stays high exactly MEM_TIMEOUT cycles.
- Reset mid-instruction aborts immediately: strobes and mem_req drop asynchronously, and no partial WB occurs.
- busA/busB/busC and MC hold their last value between instructions. Only the strobes qualify them.

## Test plan
- Reset, then start with busA=1, busB=2, busC=3, wen=1, MC=0: regRead at cycle 1, regWrite at cycle 3 with busC=3, csel=0, done at cycle 4, err=0.
- MR, mem_ack 3 cycles after mem_req: mem_req high 3 cycles, then WB with busC=34, csel=1, regWrite and workRegWrite both pulsing, then done.
- MW with no ack and MEM_TIMEOUT=15: mem_req high exactly 15 cycles, err=1, no regWrite, done pulses, and the next start clears err.
- start with wen=1, busC=35; separately, start with MC=2'b11: err=1, done at cycle 1, no strobe at all.
- rst_n pulled low during MEM: mem_req and busy fall immediately with no regWrite. After release, a new start runs the normal cycle-4 sequence.
- start held high continuously: instructions are accepted only in IDLE, exactly one every 5 cycles for register-only instructions.
